// File: rtl/mem_access_sequencer.sv
// Load/store sequencer: walks one SPARC memory op through MAR, MDR, RAM and the
// register-file write port, splitting LDD/STD into two word phases.
module mem_access_sequencer #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic       Clk,
  input  logic       RESET,
  input  logic       req,
  input  logic [5:0] op3,
  input  logic [2:0] addr_lo,
  input  logic       MFC,
  output logic       busy,
  output logic       done,
  output logic       trap_align,
  output logic       trap_illegal,
  output logic       trap_timeout,
  output logic       MAR_Enable,
  output logic       MDR_Enable,
  output logic       MDR_Mux_select,
  output logic       RAM_enable,
  output logic [5:0] RAM_OpCode,
  output logic       register_file_enable,
  output logic       second
);

  generate
    if (TIMEOUT < 2 || TIMEOUT > (2 ** CNT_W)) begin : g_bad_param
      $error("TIMEOUT must lie in 2..2**CNT_W");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE, S_MAR, S_WAIT, S_WB, S_DONE, S_TRAP
  } state_t;

  typedef enum logic [1:0] {
    T_NONE, T_ALIGN, T_ILLEGAL, T_TIMEOUT
  } trap_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state;
  trap_t            trap_q;
  logic [5:0]       op_q;
  logic             second_q;
  logic [CNT_W-1:0] cnt;

  logic is_store, is_dbl, misaligned;

  assign is_store = op_q[2];
  assign is_dbl   = (op_q[1:0] == 2'b11);

  // Alignment is judged on the incoming op, since op_q is only loaded on accept.
  always_comb begin
    misaligned = 1'b0;
    case (op3[1:0])
      2'b00:   misaligned = (addr_lo[1:0] != 2'b00);
      2'b10:   misaligned = addr_lo[0];
      2'b11:   misaligned = (addr_lo != 3'b000);
      default: misaligned = 1'b0;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (RESET) begin
      state    <= S_IDLE;
      trap_q   <= T_NONE;
      op_q     <= '0;
      second_q <= 1'b0;
      cnt      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            op_q     <= op3;
            second_q <= 1'b0;
            if (op3[5:4] != 2'b00) begin
              trap_q <= T_ILLEGAL;
              state  <= S_TRAP;
            end else if (misaligned) begin
              trap_q <= T_ALIGN;
              state  <= S_TRAP;
            end else begin
              state <= S_MAR;
            end
          end
        end
        S_MAR: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          cnt <= cnt + 1'b1;
          // MFC takes priority over an expiring counter.
          if (MFC) begin
            if (!is_store) begin
              state <= S_WB;
            end else if (is_dbl && !second_q) begin
              second_q <= 1'b1;
              state    <= S_MAR;
            end else begin
              state <= S_DONE;
            end
          end else if (cnt == CNT_LAST) begin
            trap_q <= T_TIMEOUT;
            state  <= S_TRAP;
          end
        end
        S_WB: begin
          if (is_dbl && !second_q) begin
            second_q <= 1'b1;
            state    <= S_MAR;
          end else begin
            state <= S_DONE;
          end
        end
        S_DONE: state <= S_IDLE;
        S_TRAP: begin
          trap_q <= T_NONE;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy                 = (state != S_IDLE);
    done                 = (state == S_DONE);
    trap_align           = (state == S_TRAP) && (trap_q == T_ALIGN);
    trap_illegal         = (state == S_TRAP) && (trap_q == T_ILLEGAL);
    trap_timeout         = (state == S_TRAP) && (trap_q == T_TIMEOUT);
    MAR_Enable           = 1'b0;
    MDR_Enable           = 1'b0;
    MDR_Mux_select       = 1'b0;
    RAM_enable           = 1'b0;
    RAM_OpCode           = 6'b000000;
    register_file_enable = 1'b0;
    second               = 1'b0;
    case (state)
      S_MAR: begin
        MAR_Enable = 1'b1;
        MDR_Enable = is_store;
        second     = second_q;
      end
      S_WAIT: begin
        RAM_enable     = 1'b1;
        MDR_Mux_select = !is_store;
        MDR_Enable     = !is_store && MFC;
        // Each double phase is issued to the RAM as a plain word access.
        RAM_OpCode     = is_dbl ? {3'b000, is_store, 2'b00} : op_q;
        second         = second_q;
      end
      S_WB: begin
        register_file_enable = 1'b1;
        second               = second_q;
      end
      default: ;
    endcase
  end

endmodule
